// File: rtl/day11_path_combiner_if.sv
// Stream/result bundle between the graph-search producer and day11_path_combiner.
// master: producer side (drives beats and load); slave: the combiner.
interface day11_path_combiner_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned IDX_W = 8
);
  logic             load;
  logic [WIDTH-1:0] count;
  logic             count_valid;
  logic             count_last;
  logic             ready;
  logic             done_;
  logic [WIDTH-1:0] part1_result;
  logic [WIDTH-1:0] part2_result;
  logic [IDX_W-1:0] idx;
  logic             error;
  logic             overflow;

  modport master (
    output load, count, count_valid, count_last,
    input  ready, done_, part1_result, part2_result, idx, error, overflow
  );

  modport slave (
    input  load, count, count_valid, count_last,
    output ready, done_, part1_result, part2_result, idx, error, overflow
  );
endinterface

// File: rtl/day11_path_combiner.sv
// Collects 1 + N_GROUPS*SEG path counts, then sums per-group products using one multiply per cycle.
// Optional macro DAY11_COMBINER_OVERFLOW_EN enables the sticky overflow flag.
module day11_path_combiner #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned N_GROUPS = 2,
  parameter int unsigned SEG      = 3,
  parameter int unsigned IDX_W    = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  day11_path_combiner_if.slave  bus
);

  localparam int unsigned TOTAL  = 1 + N_GROUPS * SEG;
  localparam int unsigned SIDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned G_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int unsigned K_W    = (SEG > 1) ? $clog2(SEG) : 1;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_slot [TOTAL];
  logic [WIDTH-1:0]  r_prod;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_part2;
  logic [IDX_W-1:0]  r_idx;
  logic [G_W-1:0]    r_g;
  logic [K_W-1:0]    r_k;
  logic              r_ready;
  logic              r_done;
  logic              r_error;

  logic              w_restart;
  logic              w_accept;
  logic              w_idx_final;
  logic              w_last_k;
  logic              w_last_g;
  logic [SIDX_W-1:0] w_sidx;
  logic [SIDX_W-1:0] w_widx;
  logic [WIDTH-1:0]  w_factor;
  logic [WIDTH-1:0]  w_mul;
  logic [WIDTH-1:0]  w_prod_next;
  logic [WIDTH-1:0]  w_acc_next;

  // Scheduler addressing: operand slot is 1 + g*SEG + k.
  always_comb begin
    w_restart   = clear || bus.load;
    w_accept    = (r_state == S_COLLECT) && bus.count_valid;
    w_idx_final = (r_idx == IDX_W'(TOTAL - 1));
    w_last_k    = (r_k == K_W'(SEG - 1));
    w_last_g    = (r_g == G_W'(N_GROUPS - 1));
    w_sidx      = SIDX_W'(32'd1 + 32'(r_g) * SEG + 32'(r_k));
    w_widx      = SIDX_W'(r_idx);
    w_factor    = r_slot[w_sidx];
  end

`ifdef DAY11_COMBINER_OVERFLOW_EN
  logic [2*WIDTH-1:0] w_mul_full;
  logic [WIDTH:0]     w_sum_full;
  logic               w_step_ovf;
  logic               r_overflow;

  // Full-width product and sum so the discarded carries can be observed.
  always_comb begin
    w_mul_full  = {{WIDTH{1'b0}}, r_prod} * {{WIDTH{1'b0}}, w_factor};
    w_mul       = w_mul_full[WIDTH-1:0];
    w_prod_next = (r_k == '0) ? w_factor : w_mul;
    w_sum_full  = {1'b0, r_acc} + {1'b0, w_prod_next};
    w_acc_next  = w_sum_full[WIDTH-1:0];
    w_step_ovf  = ((r_k != '0) && (w_mul_full[2*WIDTH-1:WIDTH] != '0)) ||
                  (w_last_k && w_sum_full[WIDTH]);
  end

  always_ff @(posedge clock) begin
    if (w_restart) begin
      r_overflow <= 1'b0;
    end else if (r_state == S_COMPUTE && w_step_ovf) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.overflow = r_overflow;
`else
  always_comb begin
    w_mul       = r_prod * w_factor;
    w_prod_next = (r_k == '0) ? w_factor : w_mul;
    w_acc_next  = r_acc + w_prod_next;
  end

  assign bus.overflow = 1'b0;
`endif

  // Control FSM with collection, product scheduling and result registers.
  always_ff @(posedge clock) begin
    if (w_restart) begin
      r_state <= S_COLLECT;
      r_slot  <= '{default: '0};
      r_prod  <= '0;
      r_acc   <= '0;
      r_part2 <= '0;
      r_idx   <= '0;
      r_g     <= '0;
      r_k     <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            r_slot[w_widx] <= bus.count;
            r_idx          <= r_idx + IDX_W'(1);
            if (bus.count_last || w_idx_final) begin
              r_state <= S_COMPUTE;
              r_ready <= 1'b0;
              // Early last or missing last both mean the stream length was wrong.
              if (bus.count_last != w_idx_final) begin
                r_error <= 1'b1;
              end
            end
          end
        end

        S_COMPUTE: begin
          r_prod <= w_prod_next;
          if (w_last_k) begin
            r_acc <= w_acc_next;
            r_k   <= '0;
            if (w_last_g) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_part2 <= w_acc_next;
            end else begin
              r_g <= r_g + G_W'(1);
            end
          end else begin
            r_k <= r_k + K_W'(1);
          end
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_ready <= 1'b0;
        end

        default: begin
          r_state <= S_COLLECT;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready        = r_ready;
  assign bus.done_        = r_done;
  assign bus.part1_result = r_slot[0];
  assign bus.part2_result = r_part2;
  assign bus.idx          = r_idx;
  assign bus.error        = r_error;

  // Structural invariants of the control path.
  a_ready_done_excl: assert property (@(posedge clock) disable iff (clear) !(r_ready && r_done));
  a_idx_bound:       assert property (@(posedge clock) disable iff (clear) (r_idx <= IDX_W'(TOTAL)));
  a_compute_idle:    assert property (@(posedge clock) disable iff (clear)
                                      (r_state == S_COMPUTE) |-> (!r_ready && !r_done));

endmodule

// File: tb/tb_day11_path_combiner.sv
// Bench for day11_path_combiner: directed vector table, load-abort sequence and randomized streams vs. a reference model.
module tb_day11_path_combiner;

  localparam int WIDTH    = 64;
  localparam int N_GROUPS = 2;
  localparam int SEG      = 3;
  localparam int IDX_W    = 8;
  localparam int TOTAL    = 1 + N_GROUPS * SEG;
  localparam int LAT      = N_GROUPS * SEG;
`ifdef DAY11_COMBINER_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic clear;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [63:0] stim [8];

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  day11_path_combiner_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  day11_path_combiner #(
    .WIDTH(WIDTH), .N_GROUPS(N_GROUPS), .SEG(SEG), .IDX_W(IDX_W)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0][63:0] beat;
    logic [7:0]       n_last;
    logic [7:0]       gap;
    logic [63:0]      p1;
    logic [63:0]      p2;
    logic             err;
    logic [7:0]       idx;
    logic             ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: slots from the accepted prefix, sum of group products.
  task automatic model(input int n_last, output logic [63:0] p1, output logic [63:0] p2,
                       output logic err, output int idx, output logic ovf);
    logic [63:0]  s [TOTAL];
    logic [127:0] wide;
    logic [64:0]  sum;
    logic [63:0]  acc;
    logic [63:0]  p;
    int           nacc;
    nacc = (n_last < TOTAL) ? n_last : TOTAL;
    for (int i = 0; i < TOTAL; i++) s[i] = (i < nacc) ? stim[i] : 64'd0;
    acc = 64'd0;
    ovf = 1'b0;
    for (int g = 0; g < N_GROUPS; g++) begin
      p = s[1 + g * SEG];
      for (int k = 1; k < SEG; k++) begin
        wide = {64'd0, p} * {64'd0, s[1 + g * SEG + k]};
        if (wide[127:64] != 64'd0) ovf = 1'b1;
        p = wide[63:0];
      end
      sum = {1'b0, acc} + {1'b0, p};
      if (sum[64]) ovf = 1'b1;
      acc = sum[63:0];
    end
    p1  = s[0];
    p2  = acc;
    err = (n_last != TOTAL);
    idx = nacc;
    if (!OVF_ON) ovf = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ":ready"}, 64'(bus.ready), 64'd1);
    check({tag, ":done"},  64'(bus.done_), 64'd0);
    check({tag, ":idx"},   64'(bus.idx), 64'd0);
    check({tag, ":p1"},    bus.part1_result, 64'd0);
    check({tag, ":p2"},    bus.part2_result, 64'd0);
    check({tag, ":err"},   64'(bus.error), 64'd0);
    check({tag, ":ovf"},   64'(bus.overflow), 64'd0);
  endtask

  task automatic restart(input bit use_clear, input string tag);
    if (use_clear) clear = 1'b1; else bus.load = 1'b1;
    @(negedge clock);
    clear    = 1'b0;
    bus.load = 1'b0;
    check_idle(tag);
  endtask

  // Presents beats; returns the cycle number of the edge that accepted the final beat.
  task automatic send(input int n_last, input int gap, input string tag, output int acc_cyc);
    int npres;
    int nacc;
    npres   = (n_last < TOTAL + 1) ? n_last : TOTAL + 1;
    nacc    = (n_last < TOTAL) ? n_last : TOTAL;
    acc_cyc = cyc;
    for (int i = 0; i < npres; i++) begin
      bus.count       = stim[i];
      bus.count_valid = 1'b1;
      bus.count_last  = (i + 1 == n_last);
      check({tag, (i < nacc) ? ":ready_on" : ":ready_off"}, 64'(bus.ready), (i < nacc) ? 64'd1 : 64'd0);
      @(negedge clock);
      bus.count_valid = 1'b0;
      bus.count_last  = 1'b0;
      bus.count       = 64'hDEAD_BEEF_0BAD_F00D;
      if (i == nacc - 1) acc_cyc = cyc - 1 + 1;
      if (i < nacc - 1) begin
        for (int j = 0; j < gap; j++) begin
          check({tag, ":ready_gap"}, 64'(bus.ready), 64'd1);
          @(negedge clock);
        end
      end
    end
  endtask

  task automatic wait_done_and_check(input int acc_cyc, input logic [63:0] p1, input logic [63:0] p2,
                                     input logic err, input int idx, input logic ovf, input string tag);
    int lat;
    lat = -1;
    for (int t = 0; t < 64 && lat < 0; t++) begin
      if (bus.done_) lat = cyc - acc_cyc;
      else @(negedge clock);
    end
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s:done_timeout got done_=0 expected done_=1 within 64 cycles", tag);
      return;
    end
    check({tag, ":latency"}, 64'(lat), 64'(LAT));
    check({tag, ":ready"},   64'(bus.ready), 64'd0);
    check({tag, ":p1"},      bus.part1_result, p1);
    check({tag, ":p2"},      bus.part2_result, p2);
    check({tag, ":err"},     64'(bus.error), 64'(err));
    check({tag, ":idx"},     64'(bus.idx), 64'(idx));
    check({tag, ":ovf"},     64'(bus.overflow), 64'(ovf));
    @(negedge clock);
    check({tag, ":done_hold"}, 64'(bus.done_), 64'd1);
  endtask

  function automatic vec_t mk(input logic [63:0] b0, b1, b2, b3, b4, b5, b6, b7,
                              input int n_last, input int gap, input logic [63:0] p1,
                              input logic [63:0] p2, input logic err, input int idx, input logic ovf);
    vec_t v;
    v.beat   = {b7, b6, b5, b4, b3, b2, b1, b0};
    v.n_last = 8'(n_last);
    v.gap    = 8'(gap);
    v.p1     = p1;
    v.p2     = p2;
    v.err    = err;
    v.idx    = 8'(idx);
    v.ovf    = ovf;
    return v;
  endfunction

  vec_t vecs [7];

  initial begin
    int          acc_cyc;
    int          n_last;
    int          gap;
    int          e_idx;
    logic [63:0] e_p1;
    logic [63:0] e_p2;
    logic        e_err;
    logic        e_ovf;

    vecs[0] = mk(5, 2, 3, 4, 10, 20, 30, 0, 7, 0, 5, 6024, 1'b0, 7, 1'b0);
    vecs[1] = mk(5, 2, 3, 4, 10, 20, 30, 0, 7, 2, 5, 6024, 1'b0, 7, 1'b0);
    vecs[2] = mk(7, 1, 2, 3, 0, 0, 0, 0, 4, 1, 7, 6, 1'b1, 4, 1'b0);
    vecs[3] = mk(1, 2, 3, 4, 5, 6, 7, 99, 8, 0, 1, 234, 1'b1, 7, 1'b0);
    vecs[4] = mk(9, 64'd1 << 40, 64'd1 << 30, 1, 3, 5, 7, 0, 7, 0, 9, 105, 1'b0, 7, OVF_ON);
    vecs[5] = mk(0, 64'd1 << 63, 1, 1, 64'd1 << 63, 1, 1, 0, 7, 1, 0, 0, 1'b0, 7, OVF_ON);
    vecs[6] = mk(42, 8, 8, 8, 8, 8, 8, 0, 1, 0, 42, 0, 1'b1, 1, 1'b0);

    clear           = 1'b1;
    bus.load        = 1'b0;
    bus.count       = '0;
    bus.count_valid = 1'b0;
    bus.count_last  = 1'b0;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    check_idle("reset");

    // Directed vector table.
    foreach (vecs[v]) begin
      for (int i = 0; i < 8; i++) stim[i] = vecs[v].beat[i];
      send(int'(vecs[v].n_last), int'(vecs[v].gap), $sformatf("vec%0d", v), acc_cyc);
      wait_done_and_check(acc_cyc, vecs[v].p1, vecs[v].p2, vecs[v].err, int'(vecs[v].idx),
                          vecs[v].ovf, $sformatf("vec%0d", v));
      restart(v[0], $sformatf("vec%0d_restart", v));
    end

    // Load asserted so it is sampled on the third COMPUTE edge.
    for (int i = 0; i < 8; i++) stim[i] = vecs[0].beat[i];
    send(7, 0, "abort", acc_cyc);
    while (cyc < acc_cyc + 2) @(negedge clock);
    check("abort:pre_done", 64'(bus.done_), 64'd0);
    bus.load = 1'b1;
    @(negedge clock);
    bus.load = 1'b0;
    check_idle("abort");
    repeat (8) @(negedge clock);
    check("abort:no_resume", 64'(bus.done_), 64'd0);
    send(7, 1, "post_abort", acc_cyc);
    wait_done_and_check(acc_cyc, 5, 6024, 1'b0, 7, 1'b0, "post_abort");
    restart(1'b0, "post_abort_restart");

    // Randomized streams against the reference model.
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 1) stim[i] = {$urandom, $urandom};
        else stim[i] = 64'($urandom_range(0, 1000));
      end
      n_last = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TOTAL + 1)) : TOTAL;
      gap    = int'($urandom_range(0, 2));
      model(n_last, e_p1, e_p2, e_err, e_idx, e_ovf);
      send(n_last, gap, $sformatf("rnd%0d", r), acc_cyc);
      wait_done_and_check(acc_cyc, e_p1, e_p2, e_err, e_idx, e_ovf, $sformatf("rnd%0d", r));
      restart(r[1], $sformatf("rnd%0d_restart", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/day11_path_combiner.md
Name: day11_path_combiner

Overview:
- Parametrised successor to the day-11 part-b count combiner.
- Collects a stream of path-segment counts from the graph search core. Slot 0 is the part-1 answer.
- Remaining slots form N_GROUPS groups of SEG factors each. part2_result is the sum of each group's product.
- Products use a registered, one-multiply-per-cycle scheduler instead of a combinational multiplier tree, so WIDTH/N_GROUPS/SEG scale without timing collapse.

Parameters:
WIDTH, 64, count and result width (all arithmetic modulo 2^WIDTH)
N_GROUPS, 2, number of product terms summed into part2_result
SEG, 3, factors per product term (>=1)
IDX_W, 8, width of idx; must hold TOTAL = 1 + N_GROUPS*SEG

Ports:
clock  in  1  sole clock, rising edge
clear  in  1  synchronous active-high reset
load  in  1  synchronous restart: clear slots/results, return to COLLECT
count  in  WIDTH  incoming count beat
count_valid  in  1  beat valid
count_last  in  1  final beat of stream
ready  out  1  high only in COLLECT; beat accepted when ready & count_valid
done_  out  1  results valid (DONE state)
part1_result  out  WIDTH  slot 0
part2_result  out  WIDTH  sum over groups of product of group factors
idx  out  IDX_W  beats accepted so far
error  out  1  sticky: stream length != TOTAL
overflow  out  1  sticky arithmetic overflow (see Optional Feature)

Behaviour:
- Reset (clear) and load are identical in effect; clear has priority over load. State=COLLECT, idx=0, all slots/prod/acc=0. Outputs: ready=1, done_=0, error=0, overflow=0, part1_result=0, part2_result=0.
- States: COLLECT, COMPUTE, DONE.
- COLLECT:
  - Accepted beat writes slot[idx] and increments idx.
  - Leave to COMPUTE when the accepted beat has count_last=1, or when idx==TOTAL-1 (last slot filled).
  - count_last with idx+1 < TOTAL: error=1; unfilled slots stay 0.
  - Slot TOTAL-1 filled without count_last: error=1.
  - idx saturates at TOTAL.
- COMPUTE: one operation per cycle, N_GROUPS*SEG cycles total; counters g (group) and k (factor); base = 1 + g*SEG.
  - k==0: prod <= slot[base].
  - 0<k<SEG: prod <= prod*slot[base+k] (low WIDTH bits).
  - Final step of a group also does acc <= acc + final product. For SEG==1 that step is k==0 with acc += slot[base].
  - After the last step of group N_GROUPS-1: state=DONE.
- DONE: done_=1, ready=0, part2_result=acc. Holds until load or clear.
- Latency: done_ rises on the N_GROUPS*SEG-th rising edge after the edge accepting the final beat.
- part1_result always shows slot 0. part2_result shows acc; it is 0 until DONE, since acc only updates in COMPUTE.
- load mid-COMPUTE: abort, full restart as above, no partial result kept.
- count_valid while not ready is ignored (no backpressure buffering; producer must honour ready).

Optional Feature:
Macro DAY11_COMBINER_OVERFLOW_EN.
- Defined: overflow is set sticky whenever any multiply's upper WIDTH bits are nonzero, or the accumulate carries out of WIDTH bits. Cleared only by clear/load. Results are still the truncated values.
- Undefined: overflow tied to 0; no wide-product carry logic synthesised.

Test Plan:
1. Defaults; stream 5,2,3,4,10,20,30 with last on beat 7 -> part1_result=5, part2_result=6024, error=0, idx=7, done_ rises exactly 6 cycles after final accept.
2. Same stream with count_valid gaps (2 idle cycles between beats) -> identical results; ready stays 1 throughout COLLECT.
3. count_last on beat 4 (7,1,2,3) -> part2_result=6 (group 1 zeros), error=1, idx=4.
4. 7 beats without count_last, then an extra 8th beat presented -> collection ends after beat 7, error=1, 8th beat ignored (ready=0).
5. Assert load during COMPUTE cycle 3 -> next cycle ready=1, idx=0, done_=0, results 0; a subsequent clean stream gives correct results.
6. With DAY11_COMBINER_OVERFLOW_EN and factors 2^40,2^30,1 -> overflow=1, part2_result = low 64 bits of the sum. Without the macro -> overflow=0, same part2_result.
